// File: rtl/serial_adder_if.sv
// Start/done handshake bundle for serial_adder.
// Optional macro: SERIAL_ADDER_OVF_EN adds the ovf result signal.
//   start_valid/start_ready/a/b/cin : operand handshake (master -> slave)
//   sum/cout/done_valid/done_ready  : result handshake (slave -> master)
//   busy                            : slave is in RUN or DONE
interface serial_adder_if #(
    parameter int unsigned N = 8
);
    logic         start_valid;
    logic         start_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] sum;
    logic         cout;
    logic         done_valid;
    logic         done_ready;
    logic         busy;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;

    modport master (
        output start_valid, a, b, cin, done_ready,
        input  start_ready, sum, cout, done_valid, busy, ovf
    );
    modport slave (
        input  start_valid, a, b, cin, done_ready,
        output start_ready, sum, cout, done_valid, busy, ovf
    );
`else
    modport master (
        output start_valid, a, b, cin, done_ready,
        input  start_ready, sum, cout, done_valid, busy
    );
    modport slave (
        input  start_valid, a, b, cin, done_ready,
        output start_ready, sum, cout, done_valid, busy
    );
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder cell plus a carry flop, LSB first.
// Optional macro: SERIAL_ADDER_OVF_EN adds a two's-complement overflow flag.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_adder_if.slave (operand handshake in, result handshake out)
module serial_adder #(
    parameter int unsigned N = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_adder_if.slave   bus
);
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_d;
    logic [N-1:0]  a_sr, a_sr_d;
    logic [N-1:0]  b_sr, b_sr_d;
    logic          carry, carry_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [N-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          start_ready_q, start_ready_d;
    logic          done_valid_q, done_valid_d;
    logic          busy_q, busy_d;
    logic          s_bit;
    logic          c_next;
`ifdef SERIAL_ADDER_OVF_EN
    logic          ovf_q, ovf_d;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            a_sr          <= '0;
            b_sr          <= '0;
            carry         <= 1'b0;
            cnt           <= '0;
            sum_q         <= '0;
            cout_q        <= 1'b0;
            start_ready_q <= 1'b1;
            done_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q         <= 1'b0;
`endif
        end else begin
            state         <= state_d;
            a_sr          <= a_sr_d;
            b_sr          <= b_sr_d;
            carry         <= carry_d;
            cnt           <= cnt_d;
            sum_q         <= sum_d;
            cout_q        <= cout_d;
            start_ready_q <= start_ready_d;
            done_valid_q  <= done_valid_d;
            busy_q        <= busy_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q         <= ovf_d;
`endif
        end
    end

    // Next-state, full-adder cell and next output values
    always_comb begin
        state_d = state;
        a_sr_d  = a_sr;
        b_sr_d  = b_sr;
        carry_d = carry;
        cnt_d   = cnt;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        s_bit   = a_sr[0] ^ b_sr[0] ^ carry;
        c_next  = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

        case (state)
            IDLE: begin
                if (bus.start_valid) begin
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d = c_next;
                sum_d   = {s_bit, sum_q[N-1:1]};
                a_sr_d  = {1'b0, a_sr[N-1:1]};
                b_sr_d  = {1'b0, b_sr[N-1:1]};
                cnt_d   = cnt + CW'(1);
                if (cnt == CW'(N - 1)) begin
                    cout_d  = c_next;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry register holds the carry into the MSB on this cycle
                    ovf_d   = carry ^ c_next;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.done_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake flags are registered copies of the next-state decode
        start_ready_d = (state_d == IDLE);
        done_valid_d  = (state_d == DONE);
        busy_d        = (state_d != IDLE);
    end

    assign bus.start_ready = start_ready_q;
    assign bus.done_valid  = done_valid_q;
    assign bus.busy        = busy_q;
    assign bus.sum         = sum_q;
    assign bus.cout        = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf         = ovf_q;
`endif
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder: the addition counterpart of the combinational full subtractor in the Combinational Circuits arithmetic set.
- Uses one full-adder cell and a carry flip-flop, processing one bit per clock, LSB first.
- Operands are accepted through a valid/ready start handshake; the result is returned through a valid/ready done handshake.
- Intended for area-constrained datapaths where N-cycle latency is acceptable.

Parameters:
- N, 8, operand and sum width in bits; legal range 2..32.
- CW, $clog2(N), width of the internal bit counter; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start_valid  input  1  operands a, b, cin valid
- start_ready  output  1  block can accept operands (high only in IDLE)
- a  input  N  operand A, unsigned or two's complement
- b  input  N  operand B
- cin  input  1  carry-in
- sum  output  N  result a+b+cin modulo 2^N
- cout  output  1  carry-out of the MSB
- done_valid  output  1  sum/cout valid
- done_ready  input  1  consumer accepts the result
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n).
  - While rst_n=0: state=IDLE; sum=0, cout=0, done_valid=0, busy=0, start_ready=1.
  - All internal shift registers, the counter and the carry flip-flop clear to 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On the edge where start_valid=1: load a_sr<=a, b_sr<=b, carry<=cin, cnt<=0, sum<=0 (sum register clears on accept); go to RUN.
- RUN, once per edge:
  - s = a_sr[0]^b_sr[0]^carry.
  - carry <= majority(a_sr[0], b_sr[0], carry).
  - sum <= {s, sum[N-1:1]}.
  - a_sr and b_sr shift right by one.
  - cnt <= cnt+1.
  - On the edge where cnt==N-1: cout <= the new carry; go to DONE.
- Latency: done_valid rises exactly N clocks after the accepting edge. Each operation occupies N+1 clocks minimum, from accept to the first cycle start_ready can be high again.
- DONE:
  - done_valid=1; sum and cout hold stable.
  - On the edge where done_ready=1: go to IDLE, done_valid<=0. sum and cout keep their values until the next accept.
- Backpressure: DONE persists indefinitely while done_ready=0.
- Inputs ignored outside IDLE:
  - start_valid and the a/b/cin inputs have no effect in RUN or DONE.
  - done_ready has no effect outside DONE.
- Simultaneous events: done_ready and start_valid high in the same DONE cycle → the result is consumed and the new operands are not accepted. The earliest accept is the next cycle, in IDLE.
- Reset mid-operation: the operation is aborted immediately and no partial result is ever signalled valid.
- Wrap-around: sum is modulo 2^N and overflow beyond N bits appears only on cout.
- Operand sampling: operands are sampled only at the accepting edge, so later input changes do not affect the result.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit), two's-complement overflow = (carry into bit N-1) XOR (carry out of bit N-1).
  - ovf is captured on the same edge as cout and held in DONE.
  - ovf resets to 0 and clears on accept.
- When undefined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- Latency check: N=8, accept a=8'h00, b=8'h00, cin=0 → done_valid rises exactly 8 clocks after the accepting edge; sum=8'h00, cout=0, ovf=0.
- Carry ripple: a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1, ovf=0.
- Signed overflow: a=8'h7F, b=8'h01, cin=0 → sum=8'h80, cout=0, ovf=1.
- Carry-in: a=8'hA5, b=8'h5A, cin=1 → sum=8'h00, cout=1, ovf=0.
- Backpressure: hold done_ready=0 for 5 cycles in DONE while toggling start_valid and operands → done_valid stays 1, sum/cout stable, start_ready=0. Release done_ready → IDLE next cycle, then a new operation is accepted and computed correctly.
- Reset mid-operation: assert rst_n=0 after 3 RUN cycles → sum=0, cout=0, done_valid=0, busy=0, start_ready=1 immediately. After release, a=8'h12, b=8'h34 → sum=8'h46, cout=0.
